// File: rtl/mem_if_pkg.sv
// Shared definitions for the line-granular main-memory interface:
// default widths, fetcher state encodings and the line-align helper.
package mem_if_pkg;

    localparam int ADDR_W_DEF      = 32;
    localparam int LINE_W_DEF      = 128;
    localparam int OFFSET_BITS_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        GAP  = 2'd2,
        RD   = 2'd3
    } fetch_state_t;

    function automatic logic [ADDR_W_DEF-1:0] line_align(input logic [ADDR_W_DEF-1:0] addr,
                                                          input int unsigned offset_bits);
        logic [ADDR_W_DEF-1:0] mask;
        mask = {ADDR_W_DEF{1'b1}} << offset_bits;
        return addr & mask;
    endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Down-counting mem_ready watchdog: reloads on clr, counts waiting cycles,
// flags expire on the cycle the last allowed wait cycle elapses.
module mem_watchdog #(
    parameter int unsigned LIMIT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] remaining;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            remaining <= CW'(LIMIT);
        end else if (en && (remaining != '0)) begin
            remaining <= remaining - 1'b1;
        end
    end

    assign expire = en && (remaining == CW'(1));

endmodule

// File: rtl/cache_line_fetcher.sv
// Miss fetcher: optional dirty-victim writeback, then a line read returned as a fill.
// Build option MEM_TIMEOUT_EN adds a mem_ready watchdog driving the sticky mem_err flag.
//
//   state | meaning
//   IDLE  | ready for a miss, mem_req low
//   WB    | writing the dirty victim line, waiting for mem_ready
//   GAP   | one req-low cycle so memory restarts its latency count
//   RD    | reading the missing line, waiting for mem_ready
module cache_line_fetcher
    import mem_if_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int LINE_W         = LINE_W_DEF,
    parameter int OFFSET_BITS    = OFFSET_BITS_DEF,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_valid,
    output logic              miss_ready,
    input  logic [ADDR_W-1:0] miss_addr,
    input  logic              victim_dirty,
    input  logic [ADDR_W-1:0] victim_addr,
    input  logic [LINE_W-1:0] victim_data,
    output logic              fill_valid,
    output logic [LINE_W-1:0] fill_data,
    output logic [ADDR_W-1:0] fill_addr,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              mem_err
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] miss_line;
    logic              accept;
    logic              wd_expire;

    assign accept = miss_valid && miss_ready;

`ifdef MEM_TIMEOUT_EN
    logic wd_clr;
    logic wd_en;

    assign wd_clr = accept || (state == GAP);
    assign wd_en  = ((state == WB) || (state == RD)) && !mem_ready;

    mem_watchdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk   (clk),
        .rst   (rst),
        .clr   (wd_clr),
        .en    (wd_en),
        .expire(wd_expire)
    );
`else
    assign wd_expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            miss_line  <= '0;
            miss_ready <= 1'b1;
            busy       <= 1'b0;
            fill_valid <= 1'b0;
            fill_data  <= '0;
            fill_addr  <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_err    <= 1'b0;
        end else begin
            fill_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        miss_line  <= line_align(miss_addr, OFFSET_BITS);
                        miss_ready <= 1'b0;
                        busy       <= 1'b1;
                        mem_req    <= 1'b1;
                        mem_err    <= 1'b0;
                        if (victim_dirty) begin
                            state     <= WB;
                            mem_we    <= 1'b1;
                            mem_addr  <= line_align(victim_addr, OFFSET_BITS);
                            mem_wdata <= victim_data;
                        end else begin
                            state    <= RD;
                            mem_we   <= 1'b0;
                            mem_addr <= line_align(miss_addr, OFFSET_BITS);
                        end
                    end
                end
                WB: begin
                    if (mem_ready) begin
                        state   <= GAP;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end else if (wd_expire) begin
                        state      <= IDLE;
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        mem_err    <= 1'b1;
                        miss_ready <= 1'b1;
                        busy       <= 1'b0;
                    end
                end
                GAP: begin
                    state    <= RD;
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= miss_line;
                end
                RD: begin
                    if (mem_ready) begin
                        state      <= IDLE;
                        fill_data  <= mem_rdata;
                        fill_addr  <= miss_line;
                        fill_valid <= 1'b1;
                        mem_req    <= 1'b0;
                        miss_ready <= 1'b1;
                        busy       <= 1'b0;
                    end else if (wd_expire) begin
                        state      <= IDLE;
                        mem_req    <= 1'b0;
                        mem_err    <= 1'b1;
                        miss_ready <= 1'b1;
                        busy       <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_line_fetcher.sv
// Scoreboard bench for cache_line_fetcher: a line-addressed memory responder,
// a reference model of memory contents and fill latency, and a decoupled monitor.
module tb_cache_line_fetcher;

    localparam int RESP_N  = 4;
    localparam int LAT_CLN = 6;
    localparam int LAT_DTY = 13;

    typedef struct {
        logic         we;
        logic [31:0]  addr;
        logic [127:0] wdata;
    } req_t;

    typedef struct {
        logic [31:0]  addr;
        logic [127:0] data;
        int           cyc;
    } fill_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         miss_valid;
    logic         miss_ready;
    logic [31:0]  miss_addr;
    logic         victim_dirty;
    logic [31:0]  victim_addr;
    logic [127:0] victim_data;
    logic         fill_valid;
    logic [127:0] fill_data;
    logic [31:0]  fill_addr;
    logic         busy;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;
    logic         mem_err;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    req_t  exp_req[$];
    fill_t exp_fill[$];

    logic [127:0] env_mem[logic [31:0]];
    logic [127:0] ref_mem[logic [31:0]];
    bit           spur     = 1'b0;
    bit           mem_dead = 1'b0;

    cache_line_fetcher #(
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .miss_valid  (miss_valid),
        .miss_ready  (miss_ready),
        .miss_addr   (miss_addr),
        .victim_dirty(victim_dirty),
        .victim_addr (victim_addr),
        .victim_data (victim_data),
        .fill_valid  (fill_valid),
        .fill_data   (fill_data),
        .fill_addr   (fill_addr),
        .busy        (busy),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .mem_err     (mem_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] line_init(input logic [31:0] a);
        return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'd1};
    endfunction

    function automatic logic [127:0] env_line(input logic [31:0] a);
        return env_mem.exists(a) ? env_mem[a] : line_init(a);
    endfunction

    task automatic check1(input string name, input logic act, input logic want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic check128(input string name, input logic [127:0] act, input logic [127:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic flag(input string name, input string what);
        tests++;
        fails++;
        $display("FAIL %s: %s", name, what);
    endtask

    task automatic check_idle(input string name);
        check1({name, "_mem_req"}, mem_req, 1'b0);
        check1({name, "_mem_we"}, mem_we, 1'b0);
        check32({name, "_mem_addr"}, mem_addr, 32'h0);
        check128({name, "_mem_wdata"}, mem_wdata, 128'h0);
        check1({name, "_fill_valid"}, fill_valid, 1'b0);
        check128({name, "_fill_data"}, fill_data, 128'h0);
        check32({name, "_fill_addr"}, fill_addr, 32'h0);
        check1({name, "_mem_err"}, mem_err, 1'b0);
        check1({name, "_busy"}, busy, 1'b0);
        check1({name, "_miss_ready"}, miss_ready, 1'b1);
    endtask

    // Reference model: writeback updates memory first, the read then sees it.
    task automatic issue(input logic [31:0] m, input logic d, input logic [31:0] v,
                         input logic [127:0] vd);
        int    t = 0;
        int    acc;
        logic [31:0] mline;
        logic [31:0] vline;
        fill_t f;
        miss_valid   = 1'b1;
        miss_addr    = m;
        victim_dirty = d;
        victim_addr  = v;
        victim_data  = vd;
        while (!miss_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!miss_ready) begin
            flag("accept_wait", "miss never accepted within 200 cycles");
            miss_valid = 1'b0;
            return;
        end
        acc   = cyc + 1;
        mline = m & ~32'hF;
        vline = v & ~32'hF;
        if (d) begin
            exp_req.push_back('{we: 1'b1, addr: vline, wdata: vd});
            ref_mem[vline] = vd;
        end
        exp_req.push_back('{we: 1'b0, addr: mline, wdata: 128'h0});
        f.addr = mline;
        f.data = ref_mem.exists(mline) ? ref_mem[mline] : line_init(mline);
        f.cyc  = acc + (d ? LAT_DTY : LAT_CLN);
        exp_fill.push_back(f);
        @(negedge clk);
        miss_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while ((exp_fill.size() != 0 || !miss_ready) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (exp_fill.size() != 0 || !miss_ready) flag(name, "fetcher did not drain within 100 cycles");
    endtask

    // Memory responder: ready after RESP_N+1 req-high edges, sampled away from posedge.
    initial begin : responder
        int rcnt = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_ready) begin
                mem_ready = 1'b0;
                rcnt      = 0;
            end else if (mem_req) begin
                rcnt++;
                if (rcnt == RESP_N + 2 && !mem_dead) begin
                    mem_ready = 1'b1;
                    if (mem_we) env_mem[mem_addr] = mem_wdata;
                    else        mem_rdata = env_line(mem_addr);
                end
            end else begin
                rcnt = 0;
                if (spur) begin
                    spur      = 1'b0;
                    mem_ready = 1'b1;
                    mem_rdata = {$urandom, $urandom, $urandom, $urandom};
                end
            end
        end
    end

    initial begin : monitor
        logic         prev_req = 1'b0;
        logic         prev_we  = 1'b0;
        logic [31:0]  prev_addr = '0;
        logic [127:0] prev_wdata = '0;
        req_t  r;
        fill_t f;
        forever begin
            @(negedge clk);
            if (mem_req && !prev_req) begin
                if (exp_req.size() == 0) begin
                    flag("unexpected_req", $sformatf("mem_req rose at addr %0h, none expected", mem_addr));
                end else begin
                    r = exp_req.pop_front();
                    check1("req_we", mem_we, r.we);
                    check32("req_addr", mem_addr, r.addr);
                    if (r.we) check128("req_wdata", mem_wdata, r.wdata);
                end
            end else if (mem_req && prev_req) begin
                check1("hold_we", mem_we, prev_we);
                check32("hold_addr", mem_addr, prev_addr);
                check128("hold_wdata", mem_wdata, prev_wdata);
            end
            if (fill_valid) begin
                if (exp_fill.size() == 0) begin
                    flag("unexpected_fill", $sformatf("fill at addr %0h, none expected", fill_addr));
                end else begin
                    f = exp_fill.pop_front();
                    check32("fill_addr", fill_addr, f.addr);
                    check128("fill_data", fill_data, f.data);
                    check32("fill_cycle", 32'(cyc), 32'(f.cyc));
`ifndef MEM_TIMEOUT_EN
                    check1("fill_mem_err", mem_err, 1'b0);
`endif
                end
            end
            prev_req   = mem_req;
            prev_we    = mem_we;
            prev_addr  = mem_addr;
            prev_wdata = mem_wdata;
        end
    end

    initial begin : guard
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

    initial begin : stimulus
        logic [127:0] line1;
        logic [127:0] rd;
        line1        = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        env_mem[32'h10] = line1;
        ref_mem[32'h10] = line1;
        rst          = 1'b1;
        miss_valid   = 1'b0;
        miss_addr    = '0;
        victim_dirty = 1'b0;
        victim_addr  = '0;
        victim_data  = '0;

        repeat (3) @(negedge clk);
        check_idle("in_reset");
        rst = 1'b0;
        @(negedge clk);
        check_idle("post_reset");

        issue(32'h0000_001C, 1'b0, 32'h0, 128'h0);
        wait_idle("clean_miss");

        issue(32'h0000_0000, 1'b1, 32'h0000_0008, {16{8'hA5}});
        miss_valid   = 1'b1;
        miss_addr    = 32'h70;
        victim_dirty = 1'b1;
        victim_addr  = 32'h60;
        @(negedge clk);
        miss_valid = 1'b0;
        wait_idle("dirty_miss");

        issue(32'h0000_0024, 1'b0, 32'h0, 128'h0);
        issue(32'h0000_0035, 1'b1, 32'h0000_0027, {4{32'hC0DE_F00D}});
        issue(32'h0000_0020, 1'b0, 32'h0, 128'h0);
        wait_idle("back_to_back");

        spur = 1'b1;
        repeat (4) @(negedge clk);
        check1("spur_req", mem_req, 1'b0);
        check1("spur_busy", busy, 1'b0);
        check1("spur_miss_ready", miss_ready, 1'b1);
        check1("spur_fill", fill_valid, 1'b0);

        miss_valid   = 1'b1;
        miss_addr    = 32'h40;
        victim_dirty = 1'b1;
        victim_addr  = 32'h30;
        victim_data  = {$urandom, $urandom, $urandom, $urandom};
        exp_req.push_back('{we: 1'b1, addr: 32'h30, wdata: victim_data});
        @(negedge clk);
        miss_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle("mid_wb_reset");
        repeat (20) @(negedge clk);
        issue(32'h0000_004C, 1'b0, 32'h0, 128'h0);
        wait_idle("after_reset");

`ifdef MEM_TIMEOUT_EN
        mem_dead     = 1'b1;
        miss_valid   = 1'b1;
        miss_addr    = 32'h50;
        victim_dirty = 1'b0;
        exp_req.push_back('{we: 1'b0, addr: 32'h50, wdata: 128'h0});
        @(negedge clk);
        miss_valid = 1'b0;
        repeat (7) @(negedge clk);
        check1("to_req_held", mem_req, 1'b1);
        @(negedge clk);
        check1("to_req_drop", mem_req, 1'b0);
        check1("to_err_set", mem_err, 1'b1);
        check1("to_miss_ready", miss_ready, 1'b1);
        mem_dead = 1'b0;
        issue(32'h0000_0050, 1'b0, 32'h0, 128'h0);
        check1("to_err_clear", mem_err, 1'b0);
        wait_idle("after_timeout");
`endif

        for (int i = 0; i < 40; i++) begin
            rd = {$urandom, $urandom, $urandom, $urandom};
            issue((32'($urandom_range(0, 7)) << 4) | 32'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)),
                  (32'($urandom_range(0, 7)) << 4) | 32'($urandom_range(0, 15)),
                  rd);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(negedge clk);
        end
        wait_idle("random_drain");
        repeat (5) @(negedge clk);

        check32("fills_outstanding", 32'(exp_fill.size()), 32'd0);
        check32("reqs_outstanding", 32'(exp_req.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
